lcd_bus_arbiter: RTL and testbench

- Owns the single HD44780-style character LCD bus (rs/rw/en/8-bit data).
- After reset it runs the power-on init sequence, then shares the bus between two requesters using round-robin arbitration. Requester 0 is the board/snake renderer; requester 1 is the status/"Game Over" text writer.
- It generates enable-pulse timing and post-command busy waits from counters on the system clock. This replaces the slow-clock-strobed enable.

---
 rtl/lcd_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_lcd_bus_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: power-on init and round-robin sharing of an HD44780-style character LCD bus
// Ports: clk, rst (async, active-high); req0/rs0/dat0 -> ack0 renderer write handshake;
// req1/rs1/dat1 -> ack1 status-text write handshake; lcd_rs/lcd_rw/lcd_en/lcd_dat LCD bus;
// ready = init sequence complete; busy = any state other than IDLE.
module lcd_bus_arbiter #(
    parameter int EN_SETUP = 50,
    parameter int EN_PULSE = 500,
    parameter int CMD_WAIT = 2500,
    parameter int CLR_WAIT = 100000,
    parameter int POR_WAIT = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       rs0,
    input  logic [7:0] dat0,
    output logic       ack0,
    input  logic       req1,
    input  logic       rs1,
    input  logic [7:0] dat1,
    output logic       ack1,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_dat,
    output logic       ready,
    output logic       busy
);
    localparam int M0 = EN_SETUP > EN_PULSE ? EN_SETUP : EN_PULSE;
    localparam int M1 = CMD_WAIT > CLR_WAIT ? CMD_WAIT : CLR_WAIT;
    localparam int M2 = M0 > M1 ? M0 : M1;
    localparam int MAXC = M2 > POR_WAIT ? M2 : POR_WAIT;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] C_SETUP = CW'(EN_SETUP);
    localparam logic [CW-1:0] C_PULSE = CW'(EN_PULSE);
    localparam logic [CW-1:0] C_CMD = CW'(CMD_WAIT);
    localparam logic [CW-1:0] C_CLR = CW'(CLR_WAIT);
    localparam logic [CW-1:0] C_POR = CW'(POR_WAIT);

    typedef enum logic [2:0] {POR, SETUP, PULSE, HOLD, WAIT, IDLE} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [1:0]    idx, idx_d;
    logic [7:0]    dat_d;
    logic          last_grant, last_d, rs_d, ack0_d, ack1_d, ready_d;
    logic          load, done, is_clr, pick0, pick1;

    assign lcd_rw = 1'b0;
    assign done   = cnt == CW'(1);
    // clear (0x01) and return-home (0x02/0x03) need the long post-write wait
    assign is_clr = !lcd_rs && lcd_dat[7:2] == 6'd0 && lcd_dat[1:0] != 2'd0;
    // on contention the requester that was not granted last wins
    assign pick0  = req0 && (!req1 || last_grant);
    assign pick1  = req1 && !pick0;

    always_comb begin
        state_d = state;
        cnt_d   = cnt - 1'b1;
        idx_d   = idx;
        last_d  = last_grant;
        rs_d    = lcd_rs;
        dat_d   = lcd_dat;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        ready_d = ready;
        load    = 1'b0;
        case (state)
            POR:   load = done;
            IDLE:  if (pick0 || pick1) begin
                state_d = SETUP;
                cnt_d   = C_SETUP;
                last_d  = pick1;
                rs_d    = pick1 ? rs1 : rs0;
                dat_d   = pick1 ? dat1 : dat0;
                ack0_d  = pick0;
                ack1_d  = pick1;
            end
            SETUP: if (done) begin
                state_d = PULSE;
                cnt_d   = C_PULSE;
            end
            PULSE: if (done) begin
                state_d = HOLD;
                cnt_d   = C_SETUP;
            end
            HOLD:  if (done) begin
                state_d = WAIT;
                cnt_d   = is_clr ? C_CLR : C_CMD;
            end
            WAIT:  if (done) begin
                ready_d = ready || idx == 2'd3;
                state_d = IDLE;
                load    = !ready_d;
                idx_d   = ready_d ? idx : idx + 1'b1;
            end
            default: state_d = POR;
        endcase
        // the init byte is latched on the way into SETUP, so loading costs no extra cycle
        if (load) begin
            state_d = SETUP;
            cnt_d   = C_SETUP;
            rs_d    = 1'b0;
            dat_d   = idx_d == 2'd0 ? 8'h38 : idx_d == 2'd1 ? 8'h0C : idx_d == 2'd2 ? 8'h06 : 8'h01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= POR;
            cnt        <= C_POR;
            idx        <= 2'd0;
            last_grant <= 1'b1;
            lcd_rs     <= 1'b0;
            lcd_dat    <= 8'h00;
            lcd_en     <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            ready      <= 1'b0;
            busy       <= 1'b1;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            idx        <= idx_d;
            last_grant <= last_d;
            lcd_rs     <= rs_d;
            lcd_dat    <= dat_d;
            lcd_en     <= state_d == PULSE;
            ack0       <= ack0_d;
            ack1       <= ack1_d;
            ready      <= ready_d;
            busy       <= state_d != IDLE;
        end
    end
endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter: directed self-checking bench for lcd_bus_arbiter with short timing parameters
module tb_lcd_bus_arbiter;
    logic       clk = 1'b0, rst = 1'b1;
    logic       req0 = 1'b0, rs0 = 1'b0, req1 = 1'b0, rs1 = 1'b0;
    logic [7:0] dat0 = 8'h00, dat1 = 8'h00;
    logic       ack0, ack1, lcd_rs, lcd_rw, lcd_en, ready, busy;
    logic [7:0] lcd_dat;

    int checks = 0, passes = 0;
    int mon_n = 0, ack0_n = 0, ack1_n = 0, overlap = 0;
    logic [7:0] mon_dat [16];
    logic       mon_rs [16];
    int         mon_w [16];
    logic       en_prev = 1'b0;

    logic [7:0] exp_init [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
    logic       tab_rs [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] tab_dat [5] = '{8'h01, 8'h01, 8'h03, 8'h04, 8'h00};
    int         tab_len [5] = '{14, 8, 14, 8, 8};

    always #5 clk = ~clk;

    lcd_bus_arbiter #(
        .EN_SETUP(1), .EN_PULSE(2), .CMD_WAIT(4), .CLR_WAIT(10), .POR_WAIT(5)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .rs0(rs0), .dat0(dat0), .ack0(ack0),
        .req1(req1), .rs1(rs1), .dat1(dat1), .ack1(ack1),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_dat(lcd_dat),
        .ready(ready), .busy(busy)
    );

    // records every enable pulse (byte, rs, width) and every ack
    always @(negedge clk) begin
        if (mon_n < 16) begin
            if (lcd_en && !en_prev) begin
                mon_dat[mon_n] = lcd_dat;
                mon_rs[mon_n] = lcd_rs;
                mon_w[mon_n] = 0;
            end
            if (lcd_en) mon_w[mon_n]++;
            if (!lcd_en && en_prev) mon_n++;
        end
        en_prev = lcd_en;
        if (ack0) ack0_n++;
        if (ack1) ack1_n++;
        if (ack0 && ack1) overlap++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            tick();
        end
    endtask

    // measures a transaction from the grant sample: busy length, en-high cycles, first en-high offset
    task automatic xfer(output int n, output int w, output int first_hi);
        n = 0;
        w = 0;
        first_hi = -1;
        while (busy && n < 200) begin
            if (lcd_en) begin
                w++;
                if (first_hi < 0) first_hi = n;
            end
            n++;
            tick();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (lcd_en !== 1'b0) $display("FAIL reset_en: got %b want 0", lcd_en); else passes++;
        checks++; if (lcd_rs !== 1'b0) $display("FAIL reset_rs: got %b want 0", lcd_rs); else passes++;
        checks++; if (lcd_dat !== 8'h00) $display("FAIL reset_dat: got %h want 00", lcd_dat); else passes++;
        checks++; if (lcd_rw !== 1'b0) $display("FAIL reset_rw: got %b want 0", lcd_rw); else passes++;
        checks++; if ({ack0, ack1} !== 2'b00) $display("FAIL reset_ack: got %b want 00", {ack0, ack1}); else passes++;
        checks++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy); else passes++;
    endtask

    task automatic test_init;
        int n;
        mon_n = 0;
        rst = 1'b0;
        wait_ready(n);
        checks++; if (n !== 43) $display("FAIL init_ready_time: got %0d want 43", n); else passes++;
        checks++; if (mon_n !== 4) $display("FAIL init_pulse_count: got %0d want 4", mon_n); else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (mon_dat[i] !== exp_init[i]) $display("FAIL init_dat%0d: got %h want %h", i, mon_dat[i], exp_init[i]); else passes++;
            checks++; if (mon_rs[i] !== 1'b0) $display("FAIL init_rs%0d: got %b want 0", i, mon_rs[i]); else passes++;
            checks++; if (mon_w[i] !== 2) $display("FAIL init_width%0d: got %0d want 2", i, mon_w[i]); else passes++;
        end
        checks++; if (busy !== 1'b0) $display("FAIL init_busy: got %b want 0", busy); else passes++;
    endtask

    task automatic test_single;
        int a0, n, w, f;
        a0 = ack0_n;
        req0 = 1'b1; rs0 = 1'b1; dat0 = 8'h4F;
        tick();
        checks++; if (ack0 !== 1'b1) $display("FAIL single_ack: got %b want 1", ack0); else passes++;
        checks++; if ({lcd_rs, lcd_dat} !== {1'b1, 8'h4F}) $display("FAIL single_bus: got %b/%h want 1/4f", lcd_rs, lcd_dat); else passes++;
        req0 = 1'b0;
        xfer(n, w, f);
        checks++; if (n !== 8) $display("FAIL single_busy_len: got %0d want 8", n); else passes++;
        checks++; if (w !== 2) $display("FAIL single_en_width: got %0d want 2", w); else passes++;
        checks++; if (f !== 1) $display("FAIL single_setup: got %0d want 1", f); else passes++;
        checks++; if (ack0_n - a0 !== 1) $display("FAIL single_ack_count: got %0d want 1", ack0_n - a0); else passes++;
        checks++; if ({lcd_rs, lcd_dat} !== {1'b1, 8'h4F}) $display("FAIL single_hold: got %b/%h want 1/4f", lcd_rs, lcd_dat); else passes++;
    endtask

    task automatic test_clear_wait;
        int n, w, f;
        for (int i = 0; i < 5; i++) begin
            req1 = 1'b1; rs1 = tab_rs[i]; dat1 = tab_dat[i];
            tick();
            checks++; if (ack1 !== 1'b1) $display("FAIL clear_ack%0d: got %b want 1", i, ack1); else passes++;
            req1 = 1'b0;
            xfer(n, w, f);
            checks++; if (n !== tab_len[i]) $display("FAIL clear_len%0d: rs=%b dat=%h got %0d want %0d", i, tab_rs[i], tab_dat[i], n, tab_len[i]); else passes++;
        end
    endtask

    task automatic test_contention;
        int k, cyc, n, ov;
        int order [4];
        ov = overlap;
        mon_n = 0;
        k = 0;
        cyc = 0;
        req0 = 1'b1; rs0 = 1'b1; dat0 = 8'hA0;
        req1 = 1'b1; rs1 = 1'b0; dat1 = 8'hB1;
        while (k < 4 && cyc < 200) begin
            tick();
            cyc++;
            if (ack0 || ack1) begin
                order[k] = int'(ack1);
                k++;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        wait_idle(n);
        checks++; if (k !== 4) $display("FAIL cont_grants: got %0d want 4", k); else passes++;
        for (int i = 0; i < k; i++) begin
            checks++; if (order[i] !== i % 2) $display("FAIL cont_order%0d: got %0d want %0d", i, order[i], i % 2); else passes++;
        end
        checks++; if (overlap - ov !== 0) $display("FAIL cont_overlap: got %0d want 0", overlap - ov); else passes++;
        checks++; if (mon_n !== 4) $display("FAIL cont_pulses: got %0d want 4", mon_n); else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mon_dat[i] !== (i % 2 ? 8'hB1 : 8'hA0) || mon_rs[i] !== (i % 2 == 0))
                $display("FAIL cont_bus%0d: got %b/%h want %b/%h", i, mon_rs[i], mon_dat[i], i % 2 == 0, i % 2 ? 8'hB1 : 8'hA0);
            else passes++;
        end
    endtask

    task automatic test_pre_ready;
        int n, early, w, f;
        rst = 1'b1;
        req0 = 1'b1; rs0 = 1'b1; dat0 = 8'h5A;
        tick();
        tick();
        rst = 1'b0;
        n = 0;
        early = 0;
        while (!ready && n < 200) begin
            tick();
            n++;
            if (ack0) early++;
        end
        checks++; if (early !== 0) $display("FAIL pre_early_ack: got %0d want 0", early); else passes++;
        checks++; if (n !== 43) $display("FAIL pre_ready_time: got %0d want 43", n); else passes++;
        tick();
        checks++; if (ack0 !== 1'b1) $display("FAIL pre_ack: got %b want 1", ack0); else passes++;
        checks++; if ({lcd_rs, lcd_dat} !== {1'b1, 8'h5A}) $display("FAIL pre_bus: got %b/%h want 1/5a", lcd_rs, lcd_dat); else passes++;
        req0 = 1'b0;
        xfer(n, w, f);
        checks++; if (n !== 8) $display("FAIL pre_len: got %0d want 8", n); else passes++;
    endtask

    task automatic test_reset_mid;
        int a0, c, n;
        a0 = ack0_n;
        req0 = 1'b1; rs0 = 1'b1; dat0 = 8'h33;
        tick();
        req0 = 1'b0;
        c = 0;
        while (!lcd_en && c < 20) begin
            tick();
            c++;
        end
        checks++; if (lcd_en !== 1'b1) $display("FAIL mid_reach_pulse: got %b want 1", lcd_en); else passes++;
        rst = 1'b1;
        #1;
        checks++; if (lcd_en !== 1'b0) $display("FAIL mid_en_async: got %b want 0", lcd_en); else passes++;
        checks++; if (ready !== 1'b0) $display("FAIL mid_ready: got %b want 0", ready); else passes++;
        checks++; if (ack0 !== 1'b0) $display("FAIL mid_ack: got %b want 0", ack0); else passes++;
        tick();
        rst = 1'b0;
        wait_ready(n);
        checks++; if (n !== 43) $display("FAIL mid_reinit_time: got %0d want 43", n); else passes++;
        checks++; if (ack0_n - a0 !== 1) $display("FAIL mid_ack_count: got %0d want 1", ack0_n - a0); else passes++;
    endtask

    initial begin
        test_reset();
        test_init();
        test_single();
        test_clear_wait();
        test_contention();
        test_pre_ready();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
